// File: rtl/accumulator_memory.sv
// Shared LIFO operand stack with a round-robin bus arbiter serving NUM_PROC accumulator
// processors that reduce the preloaded operands to one sum. Define ACCUM_MEM_STATS_EN for FETCH/SEND totals.
module accumulator_memory #(
  parameter  int NUM_PROC = 4,
  parameter  int DEPTH    = 32,
  localparam int PTR_W    = $clog2(DEPTH) + 1,
  localparam int OWN_W    = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  input  logic [31:0]            load_data,
  input  logic                   start,
  input  logic [NUM_PROC-1:0]    req,
  input  logic [2*NUM_PROC-1:0]  op,
  input  logic [32*NUM_PROC-1:0] write,
  output logic [NUM_PROC-1:0]    grant,
  output logic [NUM_PROC-1:0]    signal,
  output logic [31:0]            read,
  output logic                   done,
  output logic [31:0]            result,
  output logic [PTR_W-1:0]       count,
  output logic                   overflow
`ifdef ACCUM_MEM_STATS_EN
  ,
  output logic [15:0]            fetch_total,
  output logic [15:0]            send_total
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {ARB_FREE, ARB_XFER, ARB_HOLD} arb_t;

  localparam logic [1:0] OP_FETCH = 2'b01;
  localparam logic [1:0] OP_SEND  = 2'b10;

  state_t state, state_next;
  arb_t   arb, arb_next;

  logic [31:0]         stack [DEPTH];
  logic [PTR_W-1:0]    reserved;
  logic [PTR_W-1:0]    avail;
  logic [NUM_PROC-1:0] phase;
  logic [NUM_PROC-1:0] busy;
  logic [NUM_PROC-1:0] eligible;
  logic [NUM_PROC-1:0] sel_onehot;
  logic [OWN_W-1:0]    rr_ptr;
  logic [OWN_W-1:0]    owner;
  logic [OWN_W-1:0]    sel_idx;
  logic                sel_found;
  logic                full;
  logic                finish_cond;
  logic [1:0]          owner_op;
  logic [31:0]         owner_data;
  logic [PTR_W-2:0]    top_addr;
  logic                push_en;
  logic [31:0]         push_data;
  int                  rr_idx;

  assign avail      = count - reserved;
  assign full       = (count == PTR_W'(DEPTH));
  assign top_addr   = count[PTR_W-2:0] - 1'b1;
  assign owner_op   = op[2*int'(owner) +: 2];
  assign owner_data = write[32*int'(owner) +: 32];

  // An A-fetch needs two free operands; a B-fetch already has its operand reserved.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    eligible = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      case (op[2*i +: 2])
        OP_SEND:  eligible[i] = req[i];
        OP_FETCH: eligible[i] = req[i] && (phase[i] || (avail >= PTR_W'(2)));
        default:  eligible[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    rr_idx     = 0;
    sel_onehot = '0;
    for (int k = 0; k < NUM_PROC; k++) begin
      rr_idx = (int'(rr_ptr) + k) % NUM_PROC;
      if (!sel_found && eligible[rr_idx]) begin
        sel_found = 1'b1;
        sel_idx   = OWN_W'(rr_idx);
      end
    end
    sel_onehot[sel_idx] = 1'b1;
  end

  assign finish_cond = (count == PTR_W'(1)) && (reserved == '0) && (busy == '0) &&
                       (grant == '0) && (arb == ARB_FREE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && count >= PTR_W'(2))      state_next = RUN;
        else if (start && count == PTR_W'(1)) state_next = DONE;
      end
      RUN:     if (finish_cond) state_next = DONE;
      default: state_next = state;
    endcase
  end

  always_comb begin
    arb_next = arb;
    case (arb)
      ARB_FREE: if (state == RUN && sel_found && !finish_cond) arb_next = ARB_XFER;
      ARB_XFER: arb_next = ARB_HOLD;
      ARB_HOLD: if (!req[owner]) arb_next = ARB_FREE;
      default:  arb_next = ARB_FREE;
    endcase
  end

  always_comb begin
    push_en   = 1'b0;
    push_data = load_data;
    if (state == IDLE && load_valid && !full) begin
      push_en = 1'b1;
    end else if (arb == ARB_XFER && owner_op == OP_SEND) begin
      push_en   = 1'b1;
      push_data = owner_data;
    end
  end

  // NOTE: the stack array is deliberately left out of reset; count alone defines valid entries.
  always_ff @(posedge clk) begin
    if (push_en) stack[count[PTR_W-2:0]] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      arb      <= ARB_FREE;
      grant    <= '0;
      signal   <= '0;
      read     <= '0;
      done     <= 1'b0;
      result   <= '0;
      count    <= '0;
      reserved <= '0;
      phase    <= '0;
      busy     <= '0;
      overflow <= 1'b0;
      rr_ptr   <= '0;
      owner    <= '0;
    end else begin
      state  <= state_next;
      arb    <= arb_next;
      signal <= '0;
      if (state == IDLE && load_valid) begin
        if (full) overflow <= 1'b1;
        else      count    <= count + 1'b1;
      end
      case (arb)
        ARB_FREE: begin
          if (arb_next == ARB_XFER) begin
            grant  <= sel_onehot;
            owner  <= sel_idx;
            rr_ptr <= (sel_idx == OWN_W'(NUM_PROC - 1)) ? '0 : sel_idx + 1'b1;
          end
        end
        ARB_XFER: begin
          signal <= grant;
          if (owner_op == OP_FETCH) begin
            read  <= stack[top_addr];
            count <= count - 1'b1;
            if (phase[owner]) begin
              phase[owner] <= 1'b0;
              reserved     <= reserved - 1'b1;
            end else begin
              phase[owner] <= 1'b1;
              busy[owner]  <= 1'b1;
              reserved     <= reserved + 1'b1;
            end
          end else if (owner_op == OP_SEND) begin
            count       <= count + 1'b1;
            busy[owner] <= 1'b0;
          end
        end
        ARB_HOLD: if (!req[owner]) grant <= '0;
        default: ;
      endcase
      if (state != DONE && state_next == DONE) begin
        done   <= 1'b1;
        result <= stack[0];
      end
    end
  end

`ifdef ACCUM_MEM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_total <= '0;
      send_total  <= '0;
    end else if (arb == ARB_XFER) begin
      if (owner_op == OP_FETCH && fetch_total != 16'hFFFF) fetch_total <= fetch_total + 1'b1;
      if (owner_op == OP_SEND  && send_total  != 16'hFFFF) send_total  <= send_total + 1'b1;
    end
  end
`endif

endmodule

// File: doc/accumulator_memory.md
ACCUMULATOR_MEMORY -- requirements
Module: accumulator_memory

Interface
REQ-001 Parameter NUM_PROC, default 4, number of attached accumulator processors (2..8).
REQ-002 Parameter DEPTH, default 32, operand stack entries (power of 2); PTR_W = log2(DEPTH)+1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 load_valid / load_data  input  1 / 32  push one preload operand per cycle while in IDLE.
REQ-006 start  input  1  single-cycle pulse; begins reduction.
REQ-007 req  input  NUM_PROC  per-processor bus request; level, held until transaction completes.
REQ-008 op  input  2*NUM_PROC  per-processor opcode, valid while req bit high: 00 NOP, 01 FETCH, 10 SEND.
REQ-009 write  input  32*NUM_PROC  per-processor SEND data.
REQ-010 grant  output  NUM_PROC  one-hot bus grant, registered.
REQ-011 signal  output  NUM_PROC  one-cycle completion strobe to the owning processor.
REQ-012 read  output  32  FETCH data, shared, valid in the cycle signal is high.
REQ-013 done / result  output  1 / 32  reduction complete; final sum.
REQ-014 count  output  PTR_W  operands currently stored; overflow  output  1  sticky load-when-full flag.

Function
REQ-015 States SHALL be IDLE, RUN, DONE; IDLE->RUN on start when count>=2; IDLE->DONE on start when count==1; start with count==0 ignored.
REQ-016 Storage SHALL be a LIFO: FETCH pops top, SEND and load push; sums SHALL be 32-bit wrap-around (processor-computed, stored unmodified).
REQ-017 load_valid SHALL be ignored outside IDLE; load when count==DEPTH SHALL be dropped and set overflow.
REQ-018 Per-processor phase bit SHALL track first (A) vs second (B) FETCH; busy bit set on A-fetch, cleared on SEND.
REQ-019 reserved counter SHALL count busy processors awaiting B; avail = count - reserved.
REQ-020 Eligibility: SEND always eligible; A-fetch eligible only if avail>=2; B-fetch always eligible (its operand is reserved); NOP never.
REQ-021 Arbiter in FREE SHALL select the eligible requester round-robin starting after last owner; grant asserts the next cycle.
REQ-022 One transaction per grant: cycle after grant rises, signal[owner]=1 for exactly one cycle with pop (FETCH, read=top) or push (SEND, write slice).
REQ-023 A-fetch: count-1, reserved+1; B-fetch: count-1, reserved-1; SEND: count+1.
REQ-024 grant SHALL drop the cycle after req[owner] falls; arbiter returns to FREE; no back-to-back grant to same requester in that cycle.
REQ-025 RUN->DONE when count==1, reserved==0, no busy bits, no grant outstanding; done and result=stack[0] held until reset.
REQ-026 Requests in IDLE or DONE SHALL never be granted.

Reset
REQ-027 On reset: state IDLE, grant=0, signal=0, read=0, done=0, result=0, count=0, reserved=0, phase/busy=0, overflow=0, round-robin pointer=0; stack contents need not clear.
REQ-028 Reset mid-transaction SHALL abort it with no signal strobe issued.

Configuration
REQ-029 Macro ACCUM_MEM_STATS_EN: when defined, adds outputs fetch_total[15:0] and send_total[15:0], saturating counters of completed FETCH/SEND, cleared by reset; when undefined, ports and logic absent, behaviour otherwise identical.

Verification
REQ-030 Load 1,2,3,4; start; one processor -> done=1, result=10, 3 SENDs, 6 FETCHes.
REQ-031 Load 8 values 1..8, 4 processors requesting simultaneously -> grants round-robin 0,1,2,3; result=36; never two grant bits high.
REQ-032 Load 3 values, 2 processors both A-fetch -> second A-fetch withheld (avail<2) until SEND; result=sum, no deadlock.
REQ-033 Load 0xFFFFFFFF and 0x2 -> result=0x00000001 (wrap).
REQ-034 Load DEPTH+1 values -> count=DEPTH, overflow=1; start with single value -> done next cycle, result=that value.
REQ-035 Assert reset during signal cycle -> all outputs zero immediately; with ACCUM_MEM_STATS_EN, totals=0.
